truco_hand_judge: RTL and testbench

- Reads the per-round result stream that feeds the 3-slot round-history register.
- Applies Truco best-of-three rules to decide each hand, then adds the hand's value to the winner's score.
- Flags game end at WIN_SCORE.
- Sits between the round-result decoder and the scoreboard/display logic. It is the consumer of the round history.

---
 rtl/truco_pkg.sv | 25 ++
 rtl/truco_score_acc.sv | 59 +++++
 rtl/truco_hand_judge.sv | 164 ++++++++++++++++
 tb/tb_truco_hand_judge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/truco_pkg.sv
// Shared codes and state encoding for the Truco hand judge.
// Round codes, winner codes, FSM states and the default target score.
package truco_pkg;

  localparam int WIN_SCORE_DEFAULT = 12;

  localparam logic [1:0] RC_NONE = 2'b00;
  localparam logic [1:0] RC_P1   = 2'b01;
  localparam logic [1:0] RC_P2   = 2'b10;
  localparam logic [1:0] RC_TIE  = 2'b11;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_P1   = 2'b01;
  localparam logic [1:0] W_P2   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_R1,
    S_R2,
    S_R3,
    S_DONE,
    S_OVER
  } state_t;

endpackage

// File: rtl/truco_score_acc.sv
// Saturating two-player score accumulator with game-over detection.
// win_next flags that the pending add reaches the target score.
module truco_score_acc
  import truco_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEFAULT,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               clr,
  input  logic               add,
  input  logic [1:0]         winner,
  input  logic [3:0]         value,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic               win_next
);

  typedef logic [SCORE_W:0] sum_t;

  localparam sum_t WIN = sum_t'(WIN_SCORE);

  sum_t base;
  sum_t sum;
  sum_t sat;

  // Winner's score plus stake, clamped to the target.
  always_comb begin
    base     = (winner == W_P2) ? {1'b0, score2}
                                : {1'b0, score1};
    sum      = base + sum_t'(value);
    sat      = (sum >= WIN) ? WIN : sum;
    win_next = add && (winner != W_NONE)
               && (sat == WIN);
  end

  // Score registers; clr starts a fresh game.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
    end else if (clr) begin
      score1    <= '0;
      score2    <= '0;
      game_over <= 1'b0;
    end else if (add) begin
      if (winner == W_P1)
        score1 <= sat[SCORE_W-1:0];
      if (winner == W_P2)
        score2 <= sat[SCORE_W-1:0];
      if (win_next)
        game_over <= 1'b1;
    end
  end

endmodule

// File: rtl/truco_hand_judge.sv
// Truco best-of-three hand judge: round FSM plus scoring.
// TRUCO_TIE_MAO_EN: three-way tie goes to the mao player.
module truco_hand_judge
  import truco_pkg::*;
#(
  parameter int WIN_SCORE = WIN_SCORE_DEFAULT,
  parameter int SCORE_W   = 4
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               new_game,
  input  logic               new_hand,
  input  logic               mao,
  input  logic               rnd_valid,
  input  logic [1:0]         rnd_code,
  input  logic [3:0]         hand_value,
  output logic               busy,
  output logic [1:0]         rnd_idx,
  output logic               hand_done,
  output logic [1:0]         hand_winner,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over,
  output logic [1:0]         game_winner
);

  state_t     state;
  logic [1:0] r1;
  logic [1:0] r2;
  logic       mao_q;
  logic [3:0] hv_q;
  logic       dec;
  logic [1:0] dec_win;
  logic [1:0] tie_win;
  logic       win_next;
  logic       acc_add;

`ifdef TRUCO_TIE_MAO_EN
  assign tie_win = mao_q ? W_P2 : W_P1;
`else
  logic unused_mao;
  assign unused_mao = mao_q;
  assign tie_win    = W_NONE;
`endif

  // Does the incoming round decide the hand, and for whom.
  always_comb begin
    dec     = 1'b0;
    dec_win = W_NONE;
    unique case (1'b1)
      (state == S_R2): begin
        if (r1 == RC_TIE) begin
          if (rnd_code != RC_TIE) begin
            dec     = 1'b1;
            dec_win = rnd_code;
          end
        end else if (rnd_code == r1 ||
                     rnd_code == RC_TIE) begin
          dec     = 1'b1;
          dec_win = r1;
        end
      end
      (state == S_R3): begin
        dec = 1'b1;
        if (rnd_code != RC_TIE)
          dec_win = rnd_code;
        else if (r1 != RC_TIE)
          dec_win = r1;
        else
          dec_win = tie_win;
      end
      default: ;
    endcase
  end

  assign acc_add = (state == S_DONE) && !new_game;

  // Hand FSM with registered outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      rnd_idx     <= 2'd0;
      hand_done   <= 1'b0;
      hand_winner <= W_NONE;
      game_winner <= W_NONE;
      r1          <= RC_NONE;
      r2          <= RC_NONE;
      mao_q       <= 1'b0;
      hv_q        <= 4'd0;
    end else begin
      hand_done <= 1'b0;
      if (new_game) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        rnd_idx     <= 2'd0;
        hand_winner <= W_NONE;
        game_winner <= W_NONE;
        r1          <= RC_NONE;
        r2          <= RC_NONE;
      end else if (new_hand &&
                   (state == S_IDLE ||
                    state == S_R1 ||
                    state == S_R2 ||
                    state == S_R3)) begin
        state       <= S_R1;
        busy        <= 1'b1;
        rnd_idx     <= 2'd0;
        hand_winner <= W_NONE;
        mao_q       <= mao;
        r1          <= RC_NONE;
        r2          <= RC_NONE;
      end else begin
        unique case (state)
          S_R1, S_R2, S_R3: begin
            if (rnd_valid && rnd_code != RC_NONE) begin
              rnd_idx <= rnd_idx + 2'd1;
              if (dec) begin
                state       <= S_DONE;
                busy        <= 1'b0;
                hand_done   <= 1'b1;
                hand_winner <= dec_win;
                hv_q        <= hand_value;
              end else if (state == S_R1) begin
                r1    <= rnd_code;
                state <= S_R2;
              end else begin
                r2    <= rnd_code;
                state <= S_R3;
              end
            end
          end
          S_DONE: begin
            if (win_next) begin
              state       <= S_OVER;
              game_winner <= hand_winner;
            end else begin
              state <= S_IDLE;
            end
          end
          S_IDLE, S_OVER: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  truco_score_acc #(
    .WIN_SCORE (WIN_SCORE),
    .SCORE_W   (SCORE_W)
  ) u_acc (
    .clk       (clk),
    .clr_n     (clr_n),
    .clr       (new_game),
    .add       (acc_add),
    .winner    (hand_winner),
    .value     (hv_q),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over),
    .win_next  (win_next)
  );

endmodule

// File: tb/tb_truco_hand_judge.sv
// Directed bench for truco_hand_judge.
// Expected values are hand-computed per scenario.
module tb_truco_hand_judge;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       new_game;
  logic       new_hand;
  logic       mao;
  logic       rnd_valid;
  logic [1:0] rnd_code;
  logic [3:0] hand_value;
  logic       busy;
  logic [1:0] rnd_idx;
  logic       hand_done;
  logic [1:0] hand_winner;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic [1:0] game_winner;

  int errs = 0;
  int chks = 0;

`ifdef TRUCO_TIE_MAO_EN
  localparam logic [1:0] TIE3_W  = 2'b10;
  localparam int         TIE3_S2 = 4;
`else
  localparam logic [1:0] TIE3_W  = 2'b00;
  localparam int         TIE3_S2 = 3;
`endif

  always #5 clk = ~clk;

  truco_hand_judge dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .new_game    (new_game),
    .new_hand    (new_hand),
    .mao         (mao),
    .rnd_valid   (rnd_valid),
    .rnd_code    (rnd_code),
    .hand_value  (hand_value),
    .busy        (busy),
    .rnd_idx     (rnd_idx),
    .hand_done   (hand_done),
    .hand_winner (hand_winner),
    .score1      (score1),
    .score2      (score2),
    .game_over   (game_over),
    .game_winner (game_winner)
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    chks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input logic [1:0] c);
    rnd_valid = 1'b1;
    rnd_code  = c;
    tick();
    rnd_valid = 1'b0;
    rnd_code  = 2'b00;
  endtask

  task automatic nh(input logic m);
    new_hand = 1'b1;
    mao      = m;
    tick();
    new_hand = 1'b0;
  endtask

  task automatic ng();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    clr_n      = 1'b0;
    new_game   = 1'b0;
    new_hand   = 1'b0;
    mao        = 1'b0;
    rnd_valid  = 1'b0;
    rnd_code   = 2'b00;
    hand_value = 4'd0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_idx", rnd_idx, 0);
    chk("rst_done", hand_done, 0);
    chk("rst_s1", score1, 0);
    chk("rst_go", game_over, 0);
    #2 clr_n = 1'b1;
    tick();

    // 1: P1 wins two straight rounds
    nh(1'b0);
    chk("t1_busy", busy, 1);
    hand_value = 4'd1;
    rnd(2'b01);
    chk("t1_idx1", rnd_idx, 1);
    chk("t1_nodone", hand_done, 0);
    rnd(2'b01);
    chk("t1_done", hand_done, 1);
    chk("t1_win", hand_winner, 1);
    chk("t1_idx2", rnd_idx, 2);
    tick();
    chk("t1_pulse", hand_done, 0);
    chk("t1_s1", score1, 1);

    // 2: tie then P2; stake latched at decision
    nh(1'b0);
    hand_value = 4'd3;
    rnd(2'b11);
    rnd(2'b10);
    hand_value = 4'd9;
    chk("t2_done", hand_done, 1);
    chk("t2_win", hand_winner, 2);
    tick();
    chk("t2_s2", score2, 3);
    rnd(2'b01);
    chk("t2_idle_idx", rnd_idx, 2);
    chk("t2_idle_busy", busy, 0);

    // 3: split then tie -> first-round winner
    nh(1'b1);
    hand_value = 4'd1;
    rnd(2'b01);
    rnd(2'b10);
    chk("t3_busy", busy, 1);
    rnd(2'b00);
    chk("t3_code00", rnd_idx, 2);
    rnd(2'b11);
    chk("t3_done", hand_done, 1);
    chk("t3_win", hand_winner, 1);
    tick();
    chk("t3_s1", score1, 2);

    // 4: three ties with mao = P2
    nh(1'b1);
    rnd(2'b11);
    rnd(2'b11);
    chk("t4_nodone", hand_done, 0);
    rnd(2'b11);
    chk("t4_done", hand_done, 1);
    chk("t4_win", hand_winner, TIE3_W);
    tick();
    chk("t4_s2", score2, TIE3_S2);

    // 5: saturate to 12 and game over
    nh(1'b0);
    hand_value = 4'd8;
    rnd(2'b01);
    rnd(2'b01);
    tick();
    chk("t5_s1_10", score1, 10);
    nh(1'b0);
    hand_value = 4'd3;
    rnd(2'b01);
    rnd(2'b01);
    tick();
    chk("t5_sat", score1, 12);
    chk("t5_go", game_over, 1);
    chk("t5_gw", game_winner, 1);
    nh(1'b0);
    chk("t5_over_busy", busy, 0);
    rnd(2'b10);
    chk("t5_over_s2", score2, TIE3_S2);
    ng();
    chk("t5_ng_s1", score1, 0);
    chk("t5_ng_s2", score2, 0);
    chk("t5_ng_go", game_over, 0);
    chk("t5_ng_gw", game_winner, 0);

    // 6: new_hand beats rnd_valid; async reset
    nh(1'b0);
    hand_value = 4'd1;
    rnd(2'b10);
    rnd(2'b10);
    tick();
    chk("t6_s2", score2, 1);
    nh(1'b0);
    rnd(2'b01);
    new_hand  = 1'b1;
    rnd_valid = 1'b1;
    rnd_code  = 2'b01;
    tick();
    new_hand  = 1'b0;
    rnd_valid = 1'b0;
    rnd_code  = 2'b00;
    chk("t6_nodone", hand_done, 0);
    chk("t6_idx0", rnd_idx, 0);
    chk("t6_busy", busy, 1);
    chk("t6_hw0", hand_winner, 0);
    rnd(2'b01);
    chk("t6_r1_idx", rnd_idx, 1);
    chk("t6_r1_busy", busy, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_idx", rnd_idx, 0);
    chk("t6_rst_s2", score2, 0);
    #2 clr_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks",
             errs, chks);
    $finish;
  end

endmodule
